// File: rtl/image_loader_pkg.sv
// Shared definitions for the boot-time image loader: loader states,
// header word offsets inside each image, and small decode helpers.
package mips_img_pkg;

  // Loader states, in stream order.
  typedef enum logic [3:0] {
    I_PC   = 4'd0,
    I_CNT  = 4'd1,
    I_BODY = 4'd2,
    D_SP   = 4'd3,
    D_CNT  = 4'd4,
    D_WORD = 4'd5,
    D_BYTE = 4'd6,
    FIN    = 4'd7,
    DONE   = 4'd8,
    ERR    = 4'd9
  } ld_state_e;

  // Word offsets inside one image (iimage or dimage).
  localparam int HDR_ADDR = 0;
  localparam int HDR_CNT  = 1;
  localparam int BODY     = 2;

  // Default memory geometry.
  localparam int IMEM_WORDS_DEF = 256;
  localparam int DMEM_BYTES_DEF = 1024;

  // True for the states that take a word from the stream.
  function automatic logic accepts_word(input ld_state_e st);
    case (st)
      I_PC, I_CNT, I_BODY, D_SP, D_CNT, D_WORD: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      2'd3:    return w[31:24];
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/image_loader_if.sv
// Stream input, memory write ports and CPU init outputs of the image loader.
// master = the loader, slave = the stream source / memories / CPU side.
interface image_loader_if #(
  parameter int IA_W = 8,
  parameter int DA_W = 10
);
  logic            s_valid_i;
  logic [31:0]     s_data_i;
  logic            s_ready_o;
  logic            imem_we_o;
  logic [IA_W-1:0] imem_addr_o;
  logic [31:0]     imem_data_o;
  logic            dmem_we_o;
  logic [DA_W-1:0] dmem_addr_o;
  logic [7:0]      dmem_data_o;
  logic [31:0]     pc_init_o;
  logic [31:0]     sp_init_o;
  logic            init_we_o;
  logic            done_o;
  logic            err_o;

  modport master (
    input  s_valid_i, s_data_i,
    output s_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           pc_init_o, sp_init_o, init_we_o, done_o, err_o
  );

  modport slave (
    output s_valid_i, s_data_i,
    input  s_ready_o, imem_we_o, imem_addr_o, imem_data_o,
           dmem_we_o, dmem_addr_o, dmem_data_o,
           pc_init_o, sp_init_o, init_we_o, done_o, err_o
  );
endinterface

// File: rtl/image_loader_serializer.sv
// Splits one 32-bit data word into four byte writes, LSB first, on four
// consecutive cycles starting the cycle after load_i. busy_o is high while
// further beats are still to be issued after the one currently on the outputs.
module word_byte_serializer
  import mips_img_pkg::*;
#(
  parameter int DA_W = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [31:0]     word_i,
  input  logic [DA_W-1:0] base_i,
  output logic            busy_o,
  output logic            we_o,
  output logic [DA_W-1:0] addr_o,
  output logic [7:0]      data_o
);

  logic [31:0]     word_r;
  logic [DA_W-1:0] base_r;
  logic [1:0]      beat_r;
  logic            busy_r;
  logic            we_r;
  logic [DA_W-1:0] addr_r;
  logic [7:0]      data_r;

  // Beat sequencer: byte 0 goes out straight from the load, bytes 1..3 follow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_r <= 32'h0000_0000;
      base_r <= {DA_W{1'b0}};
      beat_r <= 2'd0;
      busy_r <= 1'b0;
      we_r   <= 1'b0;
      addr_r <= {DA_W{1'b0}};
      data_r <= 8'h00;
    end else if (load_i) begin
      word_r <= word_i;
      base_r <= base_i;
      beat_r <= 2'd1;
      busy_r <= 1'b1;
      we_r   <= 1'b1;
      addr_r <= base_i;
      data_r <= byte_lane(word_i, 2'd0);
    end else if (busy_r) begin
      we_r   <= 1'b1;
      addr_r <= base_r + {{(DA_W-2){1'b0}}, beat_r};
      data_r <= byte_lane(word_r, beat_r);
      busy_r <= (beat_r != 2'd3);
      beat_r <= beat_r + 2'd1;
    end else begin
      we_r <= 1'b0;
    end
  end

  assign busy_o = busy_r;
  assign we_o   = we_r;
  assign addr_o = addr_r;
  assign data_o = data_r;

endmodule

// File: rtl/image_loader.sv
// Boot-time loader: parses the iimage/dimage word stream, writes instruction
// memory (word addressed) and data memory (byte addressed, little-endian),
// then hands the initial PC and $sp to the CPU and releases it.
module image_loader
  import mips_img_pkg::*;
#(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int DMEM_BYTES = DMEM_BYTES_DEF,
  parameter int IA_W       = $clog2(IMEM_WORDS),
  parameter int DA_W       = $clog2(DMEM_BYTES)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  image_loader_if.master bus
);

  localparam logic [31:0]     I_MAX = 32'(IMEM_WORDS);
  localparam logic [31:0]     D_MAX = 32'(DMEM_BYTES / 4);
  localparam logic [IA_W:0]   K_ONE = {{IA_W{1'b0}}, 1'b1};
  localparam logic [DA_W-2:0] M_ONE = {{(DA_W-2){1'b0}}, 1'b1};
  localparam logic [DA_W-3:0] J_ONE = {{(DA_W-3){1'b0}}, 1'b1};

  ld_state_e       state_r, state_next_s;
  logic            ready_r;
  logic            hs_s;
  logic [31:0]     pc_r, sp_r;
  logic [IA_W:0]   n_r, k_r;       // wide enough to hold IMEM_WORDS itself
  logic [DA_W-2:0] m_r;            // holds DMEM_BYTES/4 itself
  logic [DA_W-3:0] j_r;            // data word index 0..M-1
  logic            imem_we_r;
  logic [IA_W-1:0] imem_addr_r;
  logic [31:0]     imem_data_r;
  logic            init_we_r, done_r, err_r;
  logic            last_body_s, last_word_s;
  logic            ser_load_s, ser_busy_s;
  logic            ser_we_s;
  logic [DA_W-1:0] ser_addr_s;
  logic [7:0]      ser_data_s;

  assign hs_s        = bus.s_valid_i & ready_r;
  assign last_body_s = (k_r == (n_r - K_ONE));
  assign last_word_s = ({1'b0, j_r} == (m_r - M_ONE));
  assign ser_load_s  = (state_r == D_WORD) & hs_s;

  // Next-state decode; the stream only advances the FSM on a handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      I_PC: begin
        if (hs_s) state_next_s = I_CNT;
        else      state_next_s = state_r;
      end
      I_CNT: begin
        if (hs_s) begin
          if (bus.s_data_i > I_MAX)          state_next_s = ERR;
          else if (bus.s_data_i == 32'd0)    state_next_s = D_SP;
          else                               state_next_s = I_BODY;
        end else begin
          state_next_s = state_r;
        end
      end
      I_BODY: begin
        if (hs_s && last_body_s) state_next_s = D_SP;
        else                     state_next_s = state_r;
      end
      D_SP: begin
        if (hs_s) state_next_s = D_CNT;
        else      state_next_s = state_r;
      end
      D_CNT: begin
        if (hs_s) begin
          if (bus.s_data_i > D_MAX)          state_next_s = ERR;
          else if (bus.s_data_i == 32'd0)    state_next_s = FIN;
          else                               state_next_s = D_WORD;
        end else begin
          state_next_s = state_r;
        end
      end
      D_WORD: begin
        if (hs_s) state_next_s = D_BYTE;
        else      state_next_s = state_r;
      end
      D_BYTE: begin
        if (!ser_busy_s) begin
          if (last_word_s) state_next_s = FIN;
          else             state_next_s = D_WORD;
        end else begin
          state_next_s = state_r;
        end
      end
      FIN:     state_next_s = DONE;
      DONE:    state_next_s = DONE;
      ERR:     state_next_s = ERR;
      default: state_next_s = ERR;
    endcase
  end

  // State register; ready is registered from the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= I_PC;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ready_r <= accepts_word(state_next_s);
    end
  end

  // Header capture: initial PC, $sp and the two counts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_r <= 32'h0000_0000;
      sp_r <= 32'h0000_0000;
      n_r  <= {(IA_W+1){1'b0}};
      m_r  <= {(DA_W-1){1'b0}};
    end else begin
      if (state_r == I_PC && hs_s)  pc_r <= bus.s_data_i;
      if (state_r == I_CNT && hs_s) n_r  <= bus.s_data_i[IA_W:0];
      if (state_r == D_SP && hs_s)  sp_r <= bus.s_data_i;
      if (state_r == D_CNT && hs_s) m_r  <= bus.s_data_i[DA_W-2:0];
    end
  end

  // Instruction body: one write strobe per accepted word at index k.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_r         <= {(IA_W+1){1'b0}};
      imem_we_r   <= 1'b0;
      imem_addr_r <= {IA_W{1'b0}};
      imem_data_r <= 32'h0000_0000;
    end else if (state_r == I_CNT) begin
      k_r       <= {(IA_W+1){1'b0}};
      imem_we_r <= 1'b0;
    end else if (state_r == I_BODY && hs_s) begin
      k_r         <= k_r + K_ONE;
      imem_we_r   <= 1'b1;
      imem_addr_r <= k_r[IA_W-1:0];
      imem_data_r <= bus.s_data_i;
    end else begin
      imem_we_r <= 1'b0;
    end
  end

  // Data word index: advances once all four bytes of a word have gone out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      j_r <= {(DA_W-2){1'b0}};
    end else if (state_r == D_CNT) begin
      j_r <= {(DA_W-2){1'b0}};
    end else if (state_r == D_BYTE && !ser_busy_s && !last_word_s) begin
      j_r <= j_r + J_ONE;
    end
  end

  // Completion and error flags; init_we is a single-cycle pulse out of FIN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_we_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      init_we_r <= (state_r == FIN);
      done_r    <= done_r | (state_r == FIN);
      err_r     <= err_r | (state_next_s == ERR);
    end
  end

  word_byte_serializer #(.DA_W(DA_W)) u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ser_load_s),
    .word_i (bus.s_data_i),
    .base_i ({j_r, 2'b00}),
    .busy_o (ser_busy_s),
    .we_o   (ser_we_s),
    .addr_o (ser_addr_s),
    .data_o (ser_data_s)
  );

  assign bus.s_ready_o   = ready_r;
  assign bus.imem_we_o   = imem_we_r;
  assign bus.imem_addr_o = imem_addr_r;
  assign bus.imem_data_o = imem_data_r;
  assign bus.dmem_we_o   = ser_we_s;
  assign bus.dmem_addr_o = ser_addr_s;
  assign bus.dmem_data_o = ser_data_s;
  assign bus.pc_init_o   = pc_r;
  assign bus.sp_init_o   = sp_r;
  assign bus.init_we_o   = init_we_r;
  assign bus.done_o      = done_r;
  assign bus.err_o       = err_r;

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: a stream-format model builds the expected memory
// write sequences; a negedge monitor checks every strobe against them.
module tb_image_loader;
  import mips_img_pkg::*;

  localparam int IMEM_WORDS = 256;
  localparam int DMEM_BYTES = 1024;
  localparam int IA_W = 8;
  localparam int DA_W = 10;

  typedef struct { int addr; logic [31:0] data; } wr_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  image_loader_if #(.IA_W(IA_W), .DA_W(DA_W)) bus ();

  image_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_BYTES(DMEM_BYTES)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  logic [31:0] stim[$];
  wr_t exp_i_q[$];
  wr_t exp_d_q[$];
  wr_t e_cmp;
  logic [31:0] exp_pc, exp_sp;
  bit exp_done, exp_err, check_en;
  int imem_cnt, dmem_cnt, init_cnt, last_iaddr, last_daddr;
  logic [31:0] imem_mem[IMEM_WORDS];
  logic [7:0] dmem_mem[DMEM_BYTES];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic outputs_or();
    return |{bus.s_ready_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o,
             bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_data_o, bus.pc_init_o,
             bus.sp_init_o, bus.init_we_o, bus.done_o, bus.err_o};
  endfunction

  // Parse the stream the way the file format defines it.
  function automatic void build_model();
    logic [31:0] n, m;
    int p;
    exp_i_q.delete(); exp_d_q.delete();
    exp_pc = 32'd0; exp_sp = 32'd0; exp_err = 1'b0; exp_done = 1'b0;
    exp_pc = stim[HDR_ADDR];
    n = stim[HDR_CNT];
    if (n > 32'(IMEM_WORDS)) begin exp_err = 1'b1; return; end
    for (int i = 0; i < int'(n); i++) exp_i_q.push_back('{i, stim[BODY + i]});
    p = BODY + int'(n);
    exp_sp = stim[p + HDR_ADDR];
    m = stim[p + HDR_CNT];
    if (m > 32'(DMEM_BYTES / 4)) begin exp_err = 1'b1; return; end
    for (int j = 0; j < int'(m); j++)
      for (int b = 0; b < 4; b++)
        exp_d_q.push_back('{4 * j + b, (stim[p + BODY + j] >> (8 * b)) & 32'h0000_00FF});
    exp_done = 1'b1;
  endfunction

  // Per-cycle monitor: every strobe must be the next expected write.
  always @(negedge clk_i) begin
    if (check_en && !rst_i) begin
      check("we_exclusive", {31'd0, bus.imem_we_o & bus.dmem_we_o}, 32'd0);
      if (bus.imem_we_o) begin
        imem_cnt++;
        last_iaddr = int'(bus.imem_addr_o);
        imem_mem[bus.imem_addr_o] = bus.imem_data_o;
        if (exp_i_q.size() == 0) check("imem_unexpected", {31'd0, bus.imem_we_o}, 32'd0);
        else begin
          e_cmp = exp_i_q.pop_front();
          check("imem_addr", 32'(bus.imem_addr_o), 32'(e_cmp.addr));
          check("imem_data", bus.imem_data_o, e_cmp.data);
        end
      end
      if (bus.dmem_we_o) begin
        dmem_cnt++;
        last_daddr = int'(bus.dmem_addr_o);
        dmem_mem[bus.dmem_addr_o] = bus.dmem_data_o;
        if (exp_d_q.size() == 0) check("dmem_unexpected", {31'd0, bus.dmem_we_o}, 32'd0);
        else begin
          e_cmp = exp_d_q.pop_front();
          check("dmem_addr", 32'(bus.dmem_addr_o), 32'(e_cmp.addr));
          check("dmem_data", 32'(bus.dmem_data_o), e_cmp.data);
        end
      end
      if (bus.init_we_o) begin
        init_cnt++;
        check("init_pc", bus.pc_init_o, exp_pc);
        check("init_sp", bus.sp_init_o, exp_sp);
      end
      if (bus.done_o) check("done_legal", {31'd0, exp_done}, 32'd1);
      if (bus.err_o)  check("err_legal",  {31'd0, exp_err},  32'd1);
    end
  end

  task automatic start_scen();
    rst_i = 1'b1;
    check_en = 1'b0;
    bus.s_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs_zero", {31'd0, outputs_or()}, 32'd0);
    build_model();
    imem_cnt = 0; dmem_cnt = 0; init_cnt = 0; last_iaddr = -1; last_daddr = -1;
    check_en = 1'b1;
    rst_i = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, output bit ok);
    bit hs;
    ok = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i = w;
    for (int c = 0; c < 400; c++) begin
      hs = bus.s_ready_o;
      @(negedge clk_i);
      if (hs) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_stream(input int gap_max);
    bit ok;
    for (int i = 0; i < stim.size(); i++) begin
      if (gap_max > 0) begin
        bus.s_valid_i = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk_i);
      end
      push_word(stim[i], ok);
      if (!ok) begin check("handshake_timeout", {31'd0, ok}, 32'd1); break; end
    end
    bus.s_valid_i = 1'b0;
  endtask

  task automatic wait_end();
    for (int c = 0; c < 4000 && !(bus.done_o || bus.err_o); c++) @(negedge clk_i);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_done"}, {31'd0, bus.done_o}, {31'd0, exp_done});
    check({tag, "_err"}, {31'd0, bus.err_o}, {31'd0, exp_err});
    check({tag, "_imem_left"}, 32'(exp_i_q.size()), 32'd0);
    check({tag, "_dmem_left"}, 32'(exp_d_q.size()), 32'd0);
    check({tag, "_init_pulses"}, 32'(init_cnt), {31'd0, exp_done});
    check({tag, "_pc"}, bus.pc_init_o, exp_pc);
    check({tag, "_sp"}, bus.sp_init_o, exp_sp);
  endtask

  task automatic scen1_literals(input string tag);
    check({tag, "_imem0"}, imem_mem[0], 32'h2008_0005);
    check({tag, "_imem1"}, imem_mem[1], 32'hFFFF_FFFF);
    check({tag, "_dmem0"}, 32'(dmem_mem[0]), 32'h44);
    check({tag, "_dmem1"}, 32'(dmem_mem[1]), 32'h33);
    check({tag, "_dmem2"}, 32'(dmem_mem[2]), 32'h22);
    check({tag, "_dmem3"}, 32'(dmem_mem[3]), 32'h11);
    check({tag, "_pc_lit"}, bus.pc_init_o, 32'h0000_0004);
    check({tag, "_sp_lit"}, bus.sp_init_o, 32'h0000_0400);
    check({tag, "_imem_strobes"}, 32'(imem_cnt), 32'd2);
    check({tag, "_dmem_strobes"}, 32'(dmem_cnt), 32'd4);
    check({tag, "_done_lit"}, {31'd0, bus.done_o}, 32'd1);
  endtask

  task automatic load_scen1();
    stim = '{32'h0000_0004, 32'd2, 32'h2008_0005, 32'hFFFF_FFFF,
             32'h0000_0400, 32'd1, 32'h1122_3344};
  endtask

  initial begin
    bit found;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = 32'd0;
    check_en = 1'b0;

    // 1: basic load, then the stream is ignored once done.
    load_scen1();
    start_scen();
    run_stream(0);
    wait_end();
    end_checks("s1");
    scen1_literals("s1");
    bus.s_valid_i = 1'b1; bus.s_data_i = 32'hDEAD_BEEF;
    repeat (5) @(negedge clk_i);
    check("s1_ready_after_done", {31'd0, bus.s_ready_o}, 32'd0);
    bus.s_valid_i = 1'b0;
    check("s1_imem_strobes_after", 32'(imem_cnt), 32'd2);

    // 2: empty images; done one cycle after FIN.
    stim = '{32'h0000_0100, 32'd0, 32'h0000_0200, 32'd0};
    start_scen();
    run_stream(0);
    check("s2_done_in_fin", {31'd0, bus.done_o}, 32'd0);
    @(negedge clk_i);
    check("s2_done_next", {31'd0, bus.done_o}, 32'd1);
    check("s2_init_we", {31'd0, bus.init_we_o}, 32'd1);
    wait_end();
    end_checks("s2");
    check("s2_no_strobes", 32'(imem_cnt + dmem_cnt), 32'd0);

    // 3: N one past the limit.
    stim = '{32'h0000_0000, 32'(IMEM_WORDS + 1)};
    start_scen();
    run_stream(0);
    check("s3_err_next", {31'd0, bus.err_o}, 32'd1);
    check("s3_ready_low", {31'd0, bus.s_ready_o}, 32'd0);
    bus.s_valid_i = 1'b1; bus.s_data_i = 32'h1234_5678;
    repeat (10) @(negedge clk_i);
    bus.s_valid_i = 1'b0;
    end_checks("s3");
    check("s3_no_imem", 32'(imem_cnt), 32'd0);

    // 3b: M with bit 31 set is out of range.
    stim = '{32'h0000_0010, 32'd1, 32'hCAFE_F00D, 32'h0000_0300, 32'h8000_0001};
    start_scen();
    run_stream(0);
    wait_end();
    end_checks("s3b");
    check("s3b_err_lit", {31'd0, bus.err_o}, 32'd1);

    // 4: scenario 1 with random stalls.
    load_scen1();
    start_scen();
    run_stream(3);
    wait_end();
    end_checks("s4");
    scen1_literals("s4");

    // 5: reset during the third byte beat, then reload.
    load_scen1();
    start_scen();
    run_stream(0);
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.dmem_we_o && bus.dmem_addr_o == 10'd2) begin found = 1'b1; break; end
      @(negedge clk_i);
    end
    check("s5_third_beat_seen", {31'd0, found}, 32'd1);
    rst_i = 1'b1;
    check_en = 1'b0;
    #1;
    check("s5_async_reset_zero", {31'd0, outputs_or()}, 32'd0);
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) dmem_mem[i] = 8'h00;
    for (int i = 0; i < 2; i++) imem_mem[i] = 32'd0;
    start_scen();
    run_stream(0);
    wait_end();
    end_checks("s5");
    scen1_literals("s5");

    // 6: both images at full size.
    stim.delete();
    stim.push_back(32'h0000_0040);
    stim.push_back(32'(IMEM_WORDS));
    for (int i = 0; i < IMEM_WORDS; i++) stim.push_back(32'h1000_0000 + 32'(i));
    stim.push_back(32'h0000_03FC);
    stim.push_back(32'(DMEM_BYTES / 4));
    for (int i = 0; i < DMEM_BYTES / 4; i++) stim.push_back(32'hA500_0000 | (32'(i) * 32'h0001_0203));
    start_scen();
    run_stream(0);
    wait_end();
    end_checks("s6");
    check("s6_last_iaddr", 32'(last_iaddr), 32'(IMEM_WORDS - 1));
    check("s6_last_daddr", 32'(last_daddr), 32'(DMEM_BYTES - 1));
    check("s6_imem_strobes", 32'(imem_cnt), 32'(IMEM_WORDS));
    check("s6_dmem_strobes", 32'(dmem_cnt), 32'(DMEM_BYTES));
    check("s6_no_err", {31'd0, bus.err_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
